// File: rtl/slice_addsub_seq.sv
// slice_addsub_seq: wide two's-complement add/subtract computed one SLICE_W-bit slice per clock
module slice_addsub_seq #(
   parameter int SLICE_W = 5,
   parameter int SLICES  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SLICE_W*SLICES-1:0]   A,
   input  logic [SLICE_W*SLICES-1:0]   B,
   input  logic                        addsub,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SLICE_W*SLICES-1:0]   S,
   output logic                        Cout,
   output logic                        ov_flag,
   output logic                        busy
);
   localparam int N  = SLICE_W * SLICES;
   localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ov_q, ov_d;
   logic [N-1:0]       a_q, a_d;
   logic [N-1:0]       b_q, b_d;
   logic [N-1:0]       s_q, s_d;
   logic [SLICE_W-1:0] a_sl, b_sl;
   logic [SLICE_W:0]   sum;
   logic               c_msb;
   logic               last;

   // Slice adder: current slice of A plus current slice of B_eff plus the carry register
   always_comb begin
      a_sl  = a_q[idx_q*SLICE_W +: SLICE_W];
      b_sl  = b_q[idx_q*SLICE_W +: SLICE_W];
      sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
      c_msb = sum[SLICE_W-1] ^ a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1];
      last  = (idx_q == IW'(SLICES - 1));
   end

   // Next-state and datapath updates for IDLE/RUN/DONE sequencing
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ov_d    = ov_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = addsub ? ~B : B;
               carry_d = addsub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[idx_q*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
            carry_d = sum[SLICE_W];
            idx_d   = last ? '0 : idx_q + 1'b1;
            if (last) begin
               cout_d  = sum[SLICE_W];
               ov_d    = c_msb ^ sum[SLICE_W];
               state_d = DONE;
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ov_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ov_q    <= ov_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign S         = s_q;
   assign Cout      = cout_q;
   assign ov_flag   = ov_q;
endmodule

// File: tb/tb_slice_addsub_seq.sv
// tb_slice_addsub_seq: directed checks of the sliced add/sub sequencer
module tb_slice_addsub_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [19:0] A = '0;
   logic [19:0] B = '0;
   logic        addsub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [19:0] S;
   logic        Cout;
   logic        ov_flag;
   logic        busy;
   int          errors = 0;
   int          checks = 0;

   slice_addsub_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .addsub(addsub), .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .Cout(Cout), .ov_flag(ov_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue an operation, wait for the result, check it, then drain it
   task automatic do_op(input string tag, input logic [19:0] a, input logic [19:0] b,
                        input logic sub, input logic [19:0] es, input logic ec, input logic ev);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 20'(in_ready), 20'h1);
      in_valid = 1'b1; A = a; B = b; addsub = sub;
      @(posedge clk);
      #1;
      in_valid = 1'b0; A = ~a; B = ~b; addsub = ~sub;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 20'(lat), 20'd4);
      check({tag, "_S"}, S, es);
      check({tag, "_Cout"}, 20'(Cout), 20'(ec));
      check({tag, "_ov"}, 20'(ov_flag), 20'(ev));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drained"}, 20'(out_valid), 20'h0);
      check({tag, "_idle_S"}, S, es);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_in_ready", 20'(in_ready), 20'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 20'(in_ready), 20'h1);
      check("rst_out_valid", 20'(out_valid), 20'h0);
      check("rst_S", S, 20'h0);
      check("rst_Cout", 20'(Cout), 20'h0);
      check("rst_ov", 20'(ov_flag), 20'h0);
      check("rst_busy", 20'(busy), 20'h0);

      do_op("add_carry", 20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0);
      do_op("add_ovf",   20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1);
      do_op("sub_borrow",20'h00005, 20'h00007, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
      do_op("sub_ovf",   20'h80000, 20'h00001, 1'b1, 20'h7FFFF, 1'b1, 1'b1);
      do_op("add_negneg",20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1);
      do_op("sub_posneg",20'h3FFFF, 20'hC0000, 1'b1, 20'h7FFFF, 1'b0, 1'b0);

      // handshake: ignored in_valid during RUN, back-pressure in DONE
      @(negedge clk);
      in_valid = 1'b1; A = 20'h12345; B = 20'h0AAAA; addsub = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; A = 20'hFFFFF; B = 20'hFFFFF; addsub = 1'b1;
      check("hs_run_in_ready", 20'(in_ready), 20'h0);
      check("hs_run_busy", 20'(busy), 20'h1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("hs_done_valid", 20'(out_valid), 20'h1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hs_hold_S", S, 20'h1CDEF);
         check("hs_hold_Cout", 20'(Cout), 20'h0);
         check("hs_hold_ov", 20'(ov_flag), 20'h0);
         check("hs_hold_in_ready", 20'(in_ready), 20'h0);
         check("hs_hold_valid", 20'(out_valid), 20'h1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs_release_idle", 20'(in_ready), 20'h1);
      do_op("hs_next", 20'h00010, 20'h00020, 1'b1, 20'hFFFF0, 1'b0, 1'b0);

      // out_ready with no result pending has no effect
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_ready_valid", 20'(out_valid), 20'h0);
      check("idle_out_ready_in_ready", 20'(in_ready), 20'h1);

      // reset mid-operation
      @(negedge clk);
      in_valid = 1'b1; A = 20'h0FFFF; B = 20'h00000; addsub = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_partial_S", 20'(S != 0), 20'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_S", S, 20'h0);
      check("midrst_in_ready", 20'(in_ready), 20'h1);
      check("midrst_busy", 20'(busy), 20'h0);
      check("midrst_out_valid", 20'(out_valid), 20'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst_no_output", 20'(out_valid), 20'h0);
      check("midrst_idle", 20'(in_ready), 20'h1);
      do_op("post_rst", 20'h12345, 20'h0AAAA, 1'b0, 20'h1CDEF, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/slice_addsub_seq.md
Name: slice_addsub_seq

Overview:
- Multi-cycle sequencer for wide two's-complement add/subtract, built on the team's 5-bit slice add/sub arithmetic.
- Latches two N-bit operands and an add/sub select, then processes one SLICE_W-bit slice per clock, LSB slice first, carrying between slices in a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Lets a narrow adder serve wide operands at a cost of SLICES cycles per operation.

Parameters:
- SLICE_W, 5, width of one slice (matches the 5-bit adder datapath)
- SLICES, 4, number of slices; operand width N = SLICE_W*SLICES (default 20)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept operands
- A  input  N  operand A
- B  input  N  operand B
- addsub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts result
- S  output  N  result
- Cout  output  1  carry out of MSB slice (subtract: 1 = no borrow, i.e. A >= B unsigned)
- ov_flag  output  1  signed overflow of the full N-bit operation
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst_n low) forces these values immediately:
  - state = IDLE, slice index = 0, carry register = 0, operand and result registers = 0.
  - in_ready = 1, out_valid = 0, S = 0, Cout = 0, ov_flag = 0, busy = 0.
- Reset mid-operation aborts the operation with no output; after release the block is in IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a rising edge: latch A, B and addsub; latch B_eff = addsub ? ~B : B; set carry register = addsub; set index = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge computes slice i: {c, s} = A[i] + B_eff[i] + carry, as a (SLICE_W+1)-bit sum.
  - Writes s into S bits [i*SLICE_W +: SLICE_W] and stores c in the carry register.
  - On the last slice (i = SLICES-1): capture Cout = c, and ov_flag = (carry into MSB of that slice) XOR c.
  - i increments by 1 per edge. On the edge that processes slice SLICES-1, go to DONE.
- DONE:
  - out_valid = 1; S, Cout and ov_flag are stable and held.
  - On out_valid && out_ready at an edge: go to IDLE, out_valid = 0.
  - S, Cout and ov_flag keep their values until the next operation's slice-0 edge.
- Latency: out_valid rises exactly SLICES edges after the accepting edge (4 by default).
- Throughput: at most one operation per SLICES+2 cycles. There is no overlap; in_ready is high only in IDLE.
- in_valid while busy is ignored; no operand is latched and there is no error.
- out_ready asserted while out_valid = 0 has no effect.
- Back-pressure: DONE holds indefinitely while out_ready = 0.
- A, B and addsub are sampled only on the accepting edge. Changes to them during RUN or DONE do not affect the result.
- S updates slice by slice during RUN. Consumers use S only when out_valid = 1.
- The index counter never exceeds SLICES-1 and is cleared on entry to RUN.

Test Plan:
- Reset: hold rst_n = 0 with clk toggling, then release → in_ready = 1, out_valid = 0, S = 0, Cout = 0, ov_flag = 0. Assert rst_n low during RUN → outputs clear immediately and state returns to IDLE.
- Add with carry across the full width: A = 0xFFFFF, B = 0x00001, addsub = 0 → S = 0x00000, Cout = 1, ov_flag = 0. out_valid rises exactly 4 edges after the accept edge.
- Signed overflow on add: A = 0x7FFFF, B = 0x00001, addsub = 0 → S = 0x80000, Cout = 0, ov_flag = 1.
- Subtract with borrow, then subtract with overflow:
  - A = 0x00005, B = 0x00007, addsub = 1 → S = 0xFFFFE, Cout = 0, ov_flag = 0.
  - A = 0x80000, B = 0x00001, addsub = 1 → S = 0x7FFFF, Cout = 1, ov_flag = 1.
- Handshake:
  - Hold out_ready = 0 for 10 cycles after out_valid → S, Cout and ov_flag are held and in_ready = 0.
  - Pulse in_valid with new operands during RUN → ignored and result unchanged.
  - Assert out_ready → IDLE on the next edge.
  - A new operation is then accepted on the following edge.
- Randomized back-to-back operations: results match an N-bit reference model for S, Cout and ov_flag. Every result appears exactly 4 edges after its accept edge.
